// File: rtl/out_writer_pkg.sv
// rtl/out_writer_pkg.sv - shared state enum, default widths and FIFO pointer sizing for the output BRAM writer
package out_writer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } writer_state_e;

   localparam int DEF_WRITE_WIDTH = 128;
   localparam int DEF_ADDR_BIT    = 10;
   localparam int DEF_FIFO_DEPTH  = 4;
   localparam int DEF_CNT_BIT     = 16;

   // One extra wrap bit distinguishes full from empty when the index bits match.
   function automatic int fifo_ptr_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/out_bram_writer_fifo.sv
// rtl/out_bram_writer_fifo.sv - synchronous skid FIFO (sync_fifo) with push-while-full allowed when popping
module sync_fifo
   import out_writer_pkg::*;
#(
   parameter int WIDTH = DEF_WRITE_WIDTH,
   parameter int DEPTH = DEF_FIFO_DEPTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int PW = fifo_ptr_w(DEPTH);
   localparam int IW = PW - 1;

   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [WIDTH-1:0] r_mem [DEPTH];
   logic             w_do_pop;
   logic             w_do_push;

   assign empty     = (r_wr_ptr == r_rd_ptr);
   assign full      = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                      (r_wr_ptr[IW-1:0] == r_rd_ptr[IW-1:0]);
   assign w_do_pop  = pop && !empty;
   // A slot freed by a same-cycle pop lets a push into a full FIFO land.
   assign w_do_push = push && (!full || w_do_pop);
   assign rdata     = r_mem[r_rd_ptr[IW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr[IW-1:0]] <= wdata;
   end

endmodule

// File: rtl/out_bram_writer.sv
// rtl/out_bram_writer.sv - writes packed result words sequentially into the output BRAM; STALL_CNT_EN adds stall_cycles
module out_bram_writer
   import out_writer_pkg::*;
#(
   parameter int WRITE_WIDTH = DEF_WRITE_WIDTH,
   parameter int ADDR_BIT    = DEF_ADDR_BIT,
   parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
   parameter int CNT_BIT     = DEF_CNT_BIT
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [ADDR_BIT-1:0]    base_addr,
   input  logic [CNT_BIT-1:0]     num_words,
   input  logic [WRITE_WIDTH-1:0] in_data,
   input  logic                   valid_i,
   input  logic                   bram_grant,
   output logic                   bram_we,
   output logic [ADDR_BIT-1:0]    bram_addr,
   output logic [WRITE_WIDTH-1:0] bram_wdata,
   output logic                   busy,
   output logic                   done,
   output logic                   overflow
`ifdef STALL_CNT_EN
   ,
   output logic [CNT_BIT-1:0]     stall_cycles
`endif
);

   writer_state_e          r_state;
   logic [ADDR_BIT-1:0]    r_addr;
   logic [CNT_BIT-1:0]     r_remaining;
   logic [WRITE_WIDTH-1:0] w_head;
   logic                   w_full;
   logic                   w_empty;
   logic                   w_pop;

   assign w_pop = (r_state == RUN) && !w_empty && bram_grant;
   assign busy  = (r_state == RUN);

   sync_fifo #(
      .WIDTH (WRITE_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (valid_i),
      .pop   (w_pop),
      .wdata (in_data),
      .rdata (w_head),
      .full  (w_full),
      .empty (w_empty)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_addr      <= '0;
         r_remaining <= '0;
         bram_we     <= 1'b0;
         bram_addr   <= '0;
         bram_wdata  <= '0;
         done        <= 1'b0;
         overflow    <= 1'b0;
      end else begin
         bram_we <= 1'b0;
         done    <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_addr      <= base_addr;
                  r_remaining <= num_words;
                  overflow    <= 1'b0;
                  r_state     <= (num_words == '0) ? DONE : RUN;
               end
            end
            RUN: begin
               if (w_pop) begin
                  bram_we     <= 1'b1;
                  bram_addr   <= r_addr;
                  bram_wdata  <= w_head;
                  r_addr      <= r_addr + ADDR_BIT'(1);
                  r_remaining <= r_remaining - CNT_BIT'(1);
                  if (r_remaining == CNT_BIT'(1)) r_state <= DONE;
               end
            end
            DONE: begin
               done    <= 1'b1;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
         // Placed after the start clear so a drop in the start cycle is still recorded.
         if (valid_i && w_full && !w_pop) overflow <= 1'b1;
      end
   end

`ifdef STALL_CNT_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cycles <= '0;
      end else if (r_state == IDLE && start) begin
         stall_cycles <= '0;
      end else if (r_state == RUN && !w_empty && !bram_grant && stall_cycles != '1) begin
         stall_cycles <= stall_cycles + CNT_BIT'(1);
      end
   end
`endif

endmodule
